// File: rtl/rr_arbiter_mux.sv
// rr_arbiter_mux: N-channel arbitrated multiplexer with a one-entry registered
// output stage and valid/ready handshakes on both sides. Arbitration is either
// round-robin (rotating from the last granted channel) or fixed priority
// (lowest index wins), selected at elaboration time.
module rr_arbiter_mux #(
    parameter int NBits         = 32,
    parameter int NCh           = 4,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCh-1:0]          In_Valid,
    input  logic [NCh*NBits-1:0]    In_Data,
    output logic [NCh-1:0]          In_Ready,
    input  logic                    Flush,
    output logic                    Out_Valid,
    output logic [NBits-1:0]        Out_Data,
    output logic [$clog2(NCh)-1:0]  Out_Sel,
    input  logic                    Out_Ready
);

    localparam int SelW = $clog2(NCh);

    logic             valid_q, valid_d;
    logic [NBits-1:0] data_q,  data_d;
    logic [SelW-1:0]  sel_q,   sel_d;
    logic [SelW-1:0]  ptr_q,   ptr_d;   // last granted channel

    logic             accept;
    logic             found;
    logic [SelW-1:0]  gnt;
    logic             in_xfer;

    // The output slot can take new data when it is empty or being drained,
    // unless a flush is discarding it this cycle.
    assign accept  = !Flush && (!valid_q || Out_Ready);
    assign in_xfer = accept && found;

    // Grant search: round-robin starts just after the last grant and wraps;
    // fixed priority always starts at channel 0.
    always_comb begin
        int              cand;
        logic [SelW-1:0] ci;
        found = 1'b0;
        gnt   = '0;
        cand  = 0;
        ci    = '0;
        for (int k = 0; k < NCh; k++) begin
            cand = (PRIORITY_MODE != 0) ? k : (int'(ptr_q) + 1 + k) % NCh;
            ci   = SelW'(cand);
            if (!found && In_Valid[ci]) begin
                found = 1'b1;
                gnt   = ci;
            end
        end
    end

    // Grant is suppressed while reset is held so no source sees a transfer.
    assign In_Ready = (in_xfer && !reset) ? (NCh'(1) << gnt) : '0;

    // Next state of the output register and the rotation pointer.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = In_Data[gnt*NBits +: NBits];
            sel_d   = gnt;
            if (PRIORITY_MODE == 0)
                ptr_d = gnt;
        end else if (Flush || Out_Ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; the pointer resets to the last channel so the first
    // round-robin search begins at channel 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= SelW'(NCh - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Out_Valid = valid_q;
    assign Out_Data  = data_q;
    assign Out_Sel   = sel_q;

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Bench for rr_arbiter_mux: a round-robin and a fixed-priority instance share
// one set of stimulus; a behavioural model tracks both and is compared every
// negative clock edge, with literal expectations for the directed scenarios.
module tb_rr_arbiter_mux;
    localparam int NB = 32;
    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NC-1:0]    in_valid = '0;
    logic [NC*NB-1:0] in_data = '0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;

    logic [NC-1:0] rdy_rr, rdy_fp;
    logic          ov_rr, ov_fp;
    logic [NB-1:0] od_rr, od_fp;
    logic [1:0]    os_rr, os_fp;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    rr_arbiter_mux #(.NBits(NB), .NCh(NC), .PRIORITY_MODE(0)) u_rr (
        .clk(clk), .reset(reset), .In_Valid(in_valid), .In_Data(in_data),
        .In_Ready(rdy_rr), .Flush(flush), .Out_Valid(ov_rr), .Out_Data(od_rr),
        .Out_Sel(os_rr), .Out_Ready(out_ready));

    rr_arbiter_mux #(.NBits(NB), .NCh(NC), .PRIORITY_MODE(1)) u_fp (
        .clk(clk), .reset(reset), .In_Valid(in_valid), .In_Data(in_data),
        .In_Ready(rdy_fp), .Flush(flush), .Out_Valid(ov_fp), .Out_Data(od_fp),
        .Out_Sel(os_fp), .Out_Ready(out_ready));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = round-robin, 1 = fixed) ----
    bit        mv[2] = '{0, 0};
    bit [31:0] md[2] = '{0, 0};
    int        ms[2] = '{0, 0};
    int        mp    = NC - 1;   // last round-robin winner

    // Winner for a request vector, or -1 when nobody asks.
    function automatic int winner(input int mode, input logic [NC-1:0] v);
        int start = (mode == 0) ? (mp + 1) % NC : 0;
        for (int k = 0; k < NC; k++)
            if (v[(start + k) % NC]) return (start + k) % NC;
        return -1;
    endfunction

    function automatic logic [NC-1:0] exp_rdy(input int mode);
        int w;
        if (reset || flush || (mv[mode] && !out_ready)) return '0;
        w = winner(mode, in_valid);
        if (w < 0) return '0;
        return NC'(1) << w;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mv = '{0, 0}; md = '{0, 0}; ms = '{0, 0}; mp = NC - 1;
        end else begin
            int w[2];
            bit x[2];
            for (int m = 0; m < 2; m++) begin
                x[m] = (exp_rdy(m) != 0);
                w[m] = winner(m, in_valid);
            end
            for (int m = 0; m < 2; m++) begin
                if (x[m]) begin
                    mv[m] = 1; md[m] = in_data[w[m]*NB +: NB]; ms[m] = w[m];
                    if (m == 0) mp = w[m];
                end else if (flush || out_ready) begin
                    mv[m] = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("rr_in_ready", rdy_rr, exp_rdy(0));
        chk("fp_in_ready", rdy_fp, exp_rdy(1));
        chk("rr_out_valid", ov_rr, mv[0]);
        chk("fp_out_valid", ov_fp, mv[1]);
        chk("rr_out_data", od_rr, md[0]);
        chk("fp_out_data", od_fp, md[1]);
        chk("rr_out_sel", os_rr, ms[0]);
        chk("fp_out_sel", os_fp, ms[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [31:0] d);
        in_data[ch*NB +: NB] = d;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state, with requests present: grants must stay low.
        in_valid = 4'b1111;
        #2;
        chk("reset_in_ready", rdy_rr, 4'b0000);
        chk("reset_out_valid", ov_rr, 1'b0);
        chk("reset_out_data", od_rr, 32'h0);
        chk("reset_out_sel", os_rr, 2'd0);
        tick();
        tick();

        // Single request on channel 2.
        in_valid  = 4'b0000;
        reset     = 1'b0;
        out_ready = 1'b1;
        set_data(2, 32'hCAFE0002);
        in_valid  = 4'b0100;
        #1;
        chk("t1_in_ready", rdy_rr, 4'b0100);
        tick();
        in_valid = 4'b0000;
        chk("t1_out_valid", ov_rr, 1'b1);
        chk("t1_out_data", od_rr, 32'hCAFE0002);
        chk("t1_out_sel", os_rr, 2'd2);

        // Round-robin rotation with all channels requesting.
        pulse_reset();
        for (int i = 0; i < NC; i++) set_data(i, 32'h1000_0000 + i);
        in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t2_rr_sel", os_rr, k % NC);
            chk("t2_rr_valid", ov_rr, 1'b1);
            chk("t2_rr_data", od_rr, 32'h1000_0000 + (k % NC));
        end

        // Fixed priority: channel 1 wins while present.
        in_valid = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_fp_sel", os_fp, 2'd1);
            chk("t3_fp_ready", rdy_fp, 4'b0010);
        end
        in_valid = 4'b1100;
        tick();
        chk("t3_fp_sel_drop", os_fp, 2'd2);

        // Stall: output held, no grants while inputs change.
        set_data(0, 32'hAAAA0000);
        in_valid = 4'b0001;
        tick();
        chk("t4_capture", od_rr, 32'hAAAA0000);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'($urandom_range(1, 15));
            set_data(k % NC, $urandom);
            #1;
            chk("t4_stall_ready", rdy_rr, 4'b0000);
            tick();
            chk("t4_stall_data", od_rr, 32'hAAAA0000);
            chk("t4_stall_sel", os_rr, 2'd0);
        end
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        #1;
        chk("t4_release_ready", rdy_rr, 4'b0010);
        tick();

        // Flush with valid output and a pending request.
        chk("t5_pre_valid", ov_rr, 1'b1);
        flush    = 1'b1;
        in_valid = 4'b0001;
        #1;
        chk("t5_flush_ready", rdy_rr, 4'b0000);
        tick();
        chk("t5_flush_valid", ov_rr, 1'b0);
        flush = 1'b0;
        #1;
        chk("t5_after_ready", rdy_rr, 4'b0001);
        tick();
        chk("t5_after_sel", os_rr, 2'd0);
        chk("t5_after_valid", ov_rr, 1'b1);

        // Asynchronous reset during streaming.
        in_valid = 4'b1111;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", ov_rr, 1'b0);
        chk("t6_async_data", od_rr, 32'h0);
        chk("t6_async_sel", os_rr, 2'd0);
        chk("t6_async_ready", rdy_rr, 4'b0000);
        in_valid = 4'b1001;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_first_ready", rdy_rr, 4'b0001);
        tick();
        chk("t6_first_sel", os_rr, 2'd0);

        // Randomized traffic, checked by the model every cycle.
        for (int k = 0; k < 400; k++) begin
            in_valid  = 4'($urandom_range(0, 15));
            for (int i = 0; i < NC; i++) set_data(i, $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            tick();
        end

        flush    = 1'b0;
        in_valid = '0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
